// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the LCD line arbiter: the controller state encoding,
// the HD44780-style command bytes used during initialisation and row
// addressing, and small helpers that map an index or row onto a command byte.
// -----------------------------------------------------------------------------
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_INIT_WAIT = 3'd0,
        ST_INIT_CMD  = 3'd1,
        ST_CLR_WAIT  = 3'd2,
        ST_IDLE      = 3'd3,
        ST_ADDR      = 3'd4,
        ST_CHAR      = 3'd5,
        ST_DONE      = 3'd6
    } lcd_state_e;

    localparam logic [7:0] CMD_FUNC_SET   = 8'h3C;
    localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] ADDR_ROW0      = 8'h80;
    localparam logic [7:0] ADDR_ROW1      = 8'hC0;

    localparam int NUM_INIT_CMDS = 4;
    localparam int NUM_CHARS     = 16;

    // Initialisation command issued in slot idx of the power-up sequence.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = CMD_FUNC_SET;
            2'd1:    cmd = CMD_DISP_ON;
            2'd2:    cmd = CMD_ENTRY_MODE;
            default: cmd = CMD_CLEAR;
        endcase
        return cmd;
    endfunction

    // DDRAM set-address command for the start of a row.
    function automatic logic [7:0] row_addr(input logic line);
        return line ? ADDR_ROW1 : ADDR_ROW0;
    endfunction

endpackage

// File: rtl/lcd_byte_slot.sv
// -----------------------------------------------------------------------------
// lcd_byte_slot
// Times one LCD byte slot of BYTE_CYC clocks. While active is high the slot
// counter runs 0..BYTE_CYC-1 and wraps, so back-to-back slots need no gap.
// Ports:
//   clk, resetn  - clock, asynchronous active-low reset
//   active       - the controller is in a state that emits bytes
//   lcd_e        - enable strobe, high in slot cycle 1 only
//   slot_done    - high in the last cycle of each slot
// -----------------------------------------------------------------------------
module lcd_byte_slot #(
    parameter int BYTE_CYC = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic active,
    output logic lcd_e,
    output logic slot_done
);

    localparam int CW = (BYTE_CYC > 1) ? $clog2(BYTE_CYC) : 1;
    localparam logic [CW-1:0] LAST  = CW'(BYTE_CYC - 1);
    localparam logic [CW-1:0] E_CYC = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (active && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign lcd_e     = active && (cnt_q == E_CYC);
    assign slot_done = active && (cnt_q == LAST);

endmodule

// File: rtl/lcd_line_arbiter.sv
// -----------------------------------------------------------------------------
// lcd_line_arbiter
// Initialises a character LCD, then arbitrates between two requesters that
// each want a full 16-character row written. A grant latches the winner's row
// and text; the block then sends one address byte and 16 character bytes and
// pulses the winner's ack.
//
// Configuration macro LCD_ARB_ROUND_ROBIN_EN:
//   defined   - a tie goes to the requester not served last
//   undefined - req0 always wins a tie (default build)
//
// Ports:
//   clk, resetn        - clock, asynchronous active-low reset
//   req0/req1          - line-write requests, held until ack
//   line0/line1        - target row (0 top, 1 bottom)
//   txt0/txt1          - 16 ASCII chars, [127:120] is column 0
//   ack0/ack1          - one-cycle completion pulses
//   ready              - idle and initialised
//   LCD_E/RS/RW/DATA   - LCD bus (RW tied low)
// -----------------------------------------------------------------------------
module lcd_line_arbiter
    import lcd_pkg::*;
#(
    parameter int BYTE_CYC  = 4,
    parameter int INIT_WAIT = 70,
    parameter int CLR_WAIT  = 200
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         req0,
    input  logic         req1,
    input  logic         line0,
    input  logic         line1,
    input  logic [127:0] txt0,
    input  logic [127:0] txt1,
    output logic         ack0,
    output logic         ack1,
    output logic         ready,
    output logic         LCD_E,
    output logic         LCD_RS,
    output logic         LCD_RW,
    output logic [7:0]   LCD_DATA
);

    localparam int WAIT_MAX = (INIT_WAIT > CLR_WAIT) ? INIT_WAIT : CLR_WAIT;
    localparam int WW       = $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0] INIT_LAST = WW'(INIT_WAIT - 1);
    localparam logic [WW-1:0] CLR_LAST  = WW'(CLR_WAIT - 1);
    localparam logic [3:0]    CMD_LAST  = 4'(NUM_INIT_CMDS - 1);
    localparam logic [3:0]    CHAR_LAST = 4'(NUM_CHARS - 1);

    lcd_state_e     state_q, state_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic [3:0]     idx_q, idx_d;
    logic [7:0]     data_q, data_d;
    logic           rs_q, rs_d;
    logic           gnt1_q, gnt1_d;
    logic           ack0_q, ack0_d;
    logic           ack1_q, ack1_d;
    logic           ready_q, ready_d;
    logic [127:0]   txt_q, txt_d;

    logic           slot_active;
    logic           slot_done;
    logic           grant_any;
    logic           grant1;
    logic [3:0]     idx_inc;

    assign idx_inc     = idx_q + 4'd1;
    assign slot_active = (state_q == ST_INIT_CMD) || (state_q == ST_ADDR) ||
                         (state_q == ST_CHAR);

    lcd_byte_slot #(
        .BYTE_CYC (BYTE_CYC)
    ) u_slot (
        .clk       (clk),
        .resetn    (resetn),
        .active    (slot_active),
        .lcd_e     (LCD_E),
        .slot_done (slot_done)
    );

    // Tie-break. last1_q remembers who was served last; it resets to 1 so
    // requester 0 wins the first tie.
`ifdef LCD_ARB_ROUND_ROBIN_EN
    logic last1_q, last1_d;

    always_comb begin
        grant_any = req0 | req1;
        grant1    = req1 & (~req0 | ~last1_q);
        last1_d   = last1_q;
        if ((state_q == ST_IDLE) && grant_any) begin
            last1_d = grant1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last1_q <= 1'b1;
        end else begin
            last1_q <= last1_d;
        end
    end
`else
    always_comb begin
        grant_any = req0 | req1;
        grant1    = req1 & ~req0;
    end
`endif

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        idx_d   = idx_q;
        data_d  = data_q;
        rs_d    = rs_q;
        gnt1_d  = gnt1_q;
        txt_d   = txt_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;

        case (state_q)
            ST_INIT_WAIT: begin
                if (wait_q == INIT_LAST) begin
                    state_d = ST_INIT_CMD;
                    wait_d  = '0;
                    idx_d   = '0;
                    data_d  = init_cmd(2'd0);
                    rs_d    = 1'b0;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            ST_INIT_CMD: begin
                if (slot_done) begin
                    if (idx_q == CMD_LAST) begin
                        state_d = ST_CLR_WAIT;
                    end else begin
                        idx_d  = idx_inc;
                        data_d = init_cmd(idx_inc[1:0]);
                    end
                end
            end
            ST_CLR_WAIT: begin
                if (wait_q == CLR_LAST) begin
                    state_d = ST_IDLE;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            ST_IDLE: begin
                // Grant in the sampling cycle; row and text are captured here
                // so the requester may change them once granted.
                if (grant_any) begin
                    state_d = ST_ADDR;
                    gnt1_d  = grant1;
                    data_d  = row_addr(grant1 ? line1 : line0);
                    rs_d    = 1'b0;
                    txt_d   = grant1 ? txt1 : txt0;
                end
            end
            ST_ADDR: begin
                // Text is consumed from the top byte and shifted up per char.
                if (slot_done) begin
                    state_d = ST_CHAR;
                    idx_d   = '0;
                    data_d  = txt_q[127:120];
                    rs_d    = 1'b1;
                    txt_d   = {txt_q[119:0], 8'h00};
                end
            end
            ST_CHAR: begin
                if (slot_done) begin
                    if (idx_q == CHAR_LAST) begin
                        state_d = ST_DONE;
                        ack0_d  = ~gnt1_q;
                        ack1_d  = gnt1_q;
                    end else begin
                        idx_d  = idx_inc;
                        data_d = txt_q[127:120];
                        txt_d  = {txt_q[119:0], 8'h00};
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT_WAIT;
                wait_d  = '0;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_INIT_WAIT;
            wait_q  <= '0;
            idx_q   <= '0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            gnt1_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            gnt1_q  <= gnt1_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            ready_q <= ready_d;
        end
    end

    // Text shift register carries payload only; reset is not needed.
    always_ff @(posedge clk) begin
        txt_q <= txt_d;
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign ready    = ready_q;
    assign LCD_RS   = rs_q;
    assign LCD_RW   = 1'b0;
    assign LCD_DATA = data_q;

endmodule

// File: tb/tb_lcd_line_arbiter.sv
module tb_lcd_line_arbiter;

    localparam int LAT       = 1 + 17 * 4;
    localparam int READY_CYC = 70 + 4 * 4 + 200;
    localparam int FIRST_E   = 71;

    logic         clk    = 1'b0;
    logic         resetn = 1'b0;
    logic         req0   = 1'b0;
    logic         req1   = 1'b0;
    logic         line0  = 1'b0;
    logic         line1  = 1'b0;
    logic [127:0] txt0   = '0;
    logic [127:0] txt1   = '0;
    logic         ack0, ack1, ready, LCD_E, LCD_RS, LCD_RW;
    logic [7:0]   LCD_DATA;

    lcd_line_arbiter dut (
        .clk      (clk),
        .resetn   (resetn),
        .req0     (req0),
        .req1     (req1),
        .line0    (line0),
        .line1    (line1),
        .txt0     (txt0),
        .txt1     (txt1),
        .ack0     (ack0),
        .ack1     (ack1),
        .ready    (ready),
        .LCD_E    (LCD_E),
        .LCD_RS   (LCD_RS),
        .LCD_RW   (LCD_RW),
        .LCD_DATA (LCD_DATA)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release: value k during the k-th cycle.
    int cyc = 0;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         cyc;
    } byte_t;

    typedef struct {
        bit r0;
        bit r1;
        bit l0;
        bit l1;
        int exp_first;
    } vec_t;

    byte_t cap_q[$];
    int    ack0_cnt = 0, ack1_cnt = 0, stab_bad = 0, e_bad = 0, rw_bad = 0;
    logic  prev_e = 1'b0;
    logic [8:0] prev_b = '0;

    function automatic byte_t mk(input logic rs, input logic [7:0] d, input int c);
        byte_t b;
        b.rs = rs; b.data = d; b.cyc = c;
        return b;
    endfunction

    // Bus monitor: records every E pulse and watches slot stability.
    always @(negedge clk) begin
        if (resetn) begin
            if (LCD_E) begin
                cap_q.push_back(mk(LCD_RS, LCD_DATA, cyc));
                if ({LCD_RS, LCD_DATA} != prev_b) stab_bad <= stab_bad + 1;
                if (prev_e) e_bad <= e_bad + 1;
            end
            if (prev_e && ({LCD_RS, LCD_DATA} != prev_b)) stab_bad <= stab_bad + 1;
            if (LCD_RW) rw_bad <= rw_bad + 1;
            if (ack0) ack0_cnt <= ack0_cnt + 1;
            if (ack1) ack1_cnt <= ack1_cnt + 1;
        end
        prev_e <= LCD_E;
        prev_b <= {LCD_RS, LCD_DATA};
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Reference arbitration: who has been served last, and who wins now.
    bit rr_last1 = 1'b1;

    function automatic int pick(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef LCD_ARB_ROUND_ROBIN_EN
            return rr_last1 ? 0 : 1;
`else
            return 0;
`endif
        end
        return r1 ? 1 : 0;
    endfunction

    // Expected {rs,data} of byte i in a row write: address, then 16 chars.
    function automatic int exp_byte(input int i, input bit line, input logic [127:0] txt);
        logic [127:0] sh;
        if (i == 0) return line ? 'h0C0 : 'h080;
        sh = txt >> (8 * (16 - i));
        return 'h100 | int'(sh[7:0]);
    endfunction

    task automatic check_bytes(input string name, input int base, input bit line,
                               input logic [127:0] txt);
        int bad = 0;
        chk({name, "_count"}, cap_q.size() - base, 17);
        for (int i = 0; i < 17; i++) begin
            if (base + i < cap_q.size()) begin
                if (((int'(cap_q[base+i].rs) << 8) | int'(cap_q[base+i].data))
                    != exp_byte(i, line, txt)) bad++;
            end
        end
        chk({name, "_bytes"}, bad, 0);
    endtask

    task automatic wait_ready(input string name, output int rc);
        int n = 0;
        while (ready !== 1'b1 && n < 1000) begin step(); n++; end
        if (ready !== 1'b1) chk({name, "_ready_timeout"}, 0, 1);
        rc = cyc;
    endtask

    // Waits for the ack, checks its cycle and width, and drops that request.
    task automatic wait_ack(input string name, input int who, input int exp_cyc);
        int n = 0;
        while (((who == 0) ? ack0 : ack1) !== 1'b1 && n < 400) begin step(); n++; end
        chk({name, "_ack_cyc"}, cyc, exp_cyc);
        chk({name, "_ack_other"}, int'((who == 0) ? ack1 : ack0), 0);
        if (who == 0) req0 = 1'b0; else req1 = 1'b0;
        step();
        chk({name, "_ack_width"}, int'((who == 0) ? ack0 : ack1), 0);
    endtask

    task automatic run_pair(input string name, input bit r0, input bit r1,
                            input bit l0, input bit l1, input int first);
        logic [127:0] t0, t1;
        int g, base, second, rc;
        wait_ready(name, rc);
        t0 = {$urandom(), $urandom(), $urandom(), $urandom()};
        t1 = {$urandom(), $urandom(), $urandom(), $urandom()};
        line0 = l0; line1 = l1; txt0 = t0; txt1 = t1;
        req0 = r0; req1 = r1;
        g = cyc; base = cap_q.size();
        step();
        // Inputs change after the grant; the latched copy must be used.
        if (first == 0) begin txt0 = ~t0; line0 = ~l0; end
        else            begin txt1 = ~t1; line1 = ~l1; end
        wait_ack(name, first, g + LAT);
        check_bytes(name, base, (first == 0) ? l0 : l1, (first == 0) ? t0 : t1);
        rr_last1 = (first == 1);
        if (r0 && r1) begin
            second = 1 - first;
            base = cap_q.size(); g = cyc;
            wait_ack({name, "_2nd"}, second, g + LAT);
            check_bytes({name, "_2nd"}, base, (second == 0) ? l0 : l1,
                        (second == 0) ? t0 : t1);
            rr_last1 = (second == 1);
        end
    endtask

    logic [7:0] init_exp [4] = '{8'h3C, 8'h0C, 8'h06, 8'h01};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc, g, base, first, a0, a1, bad;
        bit rr0, rr1;
        logic [127:0] t0, t1, hello;
        vec_t vecs [8];

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 0};

        // Reset values
        repeat (3) step();
        chk("rst_e",     int'(LCD_E), 0);
        chk("rst_rs",    int'(LCD_RS), 0);
        chk("rst_rw",    int'(LCD_RW), 0);
        chk("rst_data",  int'(LCD_DATA), 0);
        chk("rst_ack0",  int'(ack0), 0);
        chk("rst_ack1",  int'(ack1), 0);
        chk("rst_ready", int'(ready), 0);

        // Initialisation sequence
        @(negedge clk);
        resetn = 1'b1;
        wait_ready("init", rc);
        chk("init_ready_cyc", rc, READY_CYC);
        chk("init_cmd_count", cap_q.size(), 4);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (i < cap_q.size()) begin
                if (cap_q[i].data != init_exp[i] || cap_q[i].rs != 1'b0 ||
                    cap_q[i].cyc != FIRST_E + 4 * i) bad++;
            end
        end
        chk("init_cmds", bad, 0);

        // Known text to the top row
        hello = "HELLO WORLD     ";
        line0 = 1'b0; txt0 = hello; req0 = 1'b1;
        g = cyc; base = cap_q.size();
        wait_ack("hello", 0, g + LAT);
        check_bytes("hello", base, 1'b0, hello);
        rr_last1 = 1'b0;

        // Vector table
        for (int v = 0; v < 8; v++) begin
`ifdef LCD_ARB_ROUND_ROBIN_EN
            first = pick(vecs[v].r0, vecs[v].r1);
`else
            first = vecs[v].exp_first;
`endif
            run_pair($sformatf("vec%0d", v), vecs[v].r0, vecs[v].r1,
                     vecs[v].l0, vecs[v].l1, first);
        end

        // Randomized requests against the reference model
        for (int k = 0; k < 6; k++) begin
            rr0 = 1'($urandom_range(0, 1));
            rr1 = rr0 ? 1'($urandom_range(0, 1)) : 1'b1;
            run_pair($sformatf("rnd%0d", k), rr0, rr1, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), pick(rr0, rr1));
        end

        // req1 raised during req0's transfer
        wait_ready("late", rc);
        t0 = {$urandom(), $urandom(), $urandom(), $urandom()};
        t1 = {$urandom(), $urandom(), $urandom(), $urandom()};
        line0 = 1'b0; txt0 = t0; req0 = 1'b1;
        g = cyc; base = cap_q.size();
        repeat (20) step();
        line1 = 1'b1; txt1 = t1; req1 = 1'b1;
        wait_ack("late_a", 0, g + LAT);
        check_bytes("late_a", base, 1'b0, t0);
        base = cap_q.size(); g = cyc;
        wait_ack("late_b", 1, g + LAT);
        check_bytes("late_b", base, 1'b1, t1);
        rr_last1 = 1'b1;

        // req0 dropped after grant; req1 raised and withdrawn meanwhile
        wait_ready("drop", rc);
        t0 = {$urandom(), $urandom(), $urandom(), $urandom()};
        line0 = 1'b1; txt0 = t0; req0 = 1'b1;
        g = cyc; base = cap_q.size(); a1 = ack1_cnt;
        repeat (10) step();
        req0 = 1'b0; req1 = 1'b1; line1 = 1'b0;
        repeat (20) step();
        req1 = 1'b0;
        wait_ack("drop", 0, g + LAT);
        check_bytes("drop", base, 1'b1, t0);
        rr_last1 = 1'b0;
        repeat (100) step();
        chk("withdraw_no_ack1", ack1_cnt - a1, 0);
        chk("withdraw_ready", int'(ready), 1);

        // Reset in the middle of a character slot
        wait_ready("midrst", rc);
        line0 = 1'b1; txt0 = {$urandom(), $urandom(), $urandom(), $urandom()};
        req0 = 1'b1;
        repeat (30) step();
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst_e",     int'(LCD_E), 0);
        chk("midrst_rs",    int'(LCD_RS), 0);
        chk("midrst_data",  int'(LCD_DATA), 0);
        chk("midrst_ready", int'(ready), 0);
        chk("midrst_ack",   int'(ack0 | ack1), 0);
        a0 = ack0_cnt;
        req0 = 1'b0;
        rr_last1 = 1'b1;
        repeat (2) step();
        @(negedge clk);
        resetn = 1'b1;
        base = cap_q.size();
        wait_ready("midrst", rc);
        chk("midrst_ready_cyc", rc, READY_CYC);
        chk("midrst_no_ack", ack0_cnt - a0, 0);
        chk("midrst_restart_cnt", cap_q.size() - base, 4);
        if (cap_q.size() > base) begin
            chk("midrst_first_cmd", int'(cap_q[base].data), 'h3C);
            chk("midrst_first_cyc", cap_q[base].cyc, FIRST_E);
        end

        // First tie after reset goes to requester 0
        run_pair("post_rst_tie", 1'b1, 1'b1, 1'b0, 1'b1, pick(1'b1, 1'b1));

        chk("slot_stability", stab_bad, 0);
        chk("e_single_cycle", e_bad, 0);
        chk("rw_low", rw_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_line_arbiter.md
LCD_LINE_ARBITER -- requirements
Module: lcd_line_arbiter

Interface
REQ-001 The block SHALL have parameter BYTE_CYC, default 4, giving clocks per LCD byte slot; legal values are 3 and above.
REQ-002 The block SHALL have parameter INIT_WAIT, default 70, giving the number of clocks after reset release before the first command.
REQ-003 The block SHALL have parameter CLR_WAIT, default 200, giving the number of idle clocks after the clear-display command.
REQ-004 Port clk SHALL be an input, 1 bit wide: the single system clock; all logic is rising-edge.
REQ-005 Port resetn SHALL be an input, 1 bit wide: the reset, asynchronous and active-low.
REQ-006 Ports req0 and req1 SHALL be inputs, 1 bit each: line-write requests.
REQ-007 Ports line0 and line1 SHALL be inputs, 1 bit each: target row per requester, where 0 is the top row and 1 the bottom row.
REQ-008 Ports txt0 and txt1 SHALL be inputs, 128 bits each: 16 ASCII characters per requester, with bits [127:120] holding column 0.
REQ-009 Ports ack0 and ack1 SHALL be outputs, 1 bit each: one-cycle completion pulse per requester.
REQ-010 Port ready SHALL be an output, 1 bit wide: high while the block is idle after initialisation.
REQ-011 Port LCD_E SHALL be an output, 1 bit wide: LCD enable strobe.
REQ-012 Ports LCD_RS and LCD_RW SHALL be outputs, 1 bit each: register select and read/write; LCD_RW is always 0.
REQ-013 Port LCD_DATA SHALL be an output, 8 bits wide: LCD data bus.

Function
REQ-014 Each byte SHALL occupy one slot of BYTE_CYC clocks.
REQ-015 Within a slot, LCD_RS and LCD_DATA SHALL be stable for the whole slot, LCD_E SHALL be 1 only in slot cycle 1, and LCD_E SHALL be 0 in all other cycles.
REQ-016 The FSM states SHALL be: INIT_WAIT, INIT_CMD, CLR_WAIT, IDLE, ADDR, CHAR, DONE.
REQ-017 INIT_WAIT SHALL count INIT_WAIT clocks and then enter INIT_CMD.
REQ-018 INIT_CMD SHALL issue four command slots (RS=0) carrying 0x3C, 0x0C, 0x06 and 0x01 in that order, then enter CLR_WAIT.
REQ-019 CLR_WAIT SHALL count CLR_WAIT clocks and then enter IDLE, so that ready first rises at clock INIT_WAIT+4*BYTE_CYC+CLR_WAIT after reset release.
REQ-020 In IDLE, ready SHALL be 1 and LCD_DATA SHALL hold its last value with LCD_E=0; in every other state ready SHALL be 0.
REQ-021 In IDLE, a sampled request SHALL be granted in that same cycle, and the granted requester's line and txt SHALL be latched at the grant.
REQ-022 After the grant, the block SHALL enter ADDR: one RS=0 slot with 0x80 for row 0 or 0xC0 for row 1.
REQ-023 After ADDR, CHAR SHALL issue 16 RS=1 slots carrying the latched characters, column 0 first.
REQ-024 After CHAR, DONE SHALL last 1 cycle, assert ack for the granted requester only, and return to IDLE.
REQ-025 The latency from grant to ack SHALL be 1+17*BYTE_CYC clocks, which is 69 at the default.
REQ-026 A requester SHALL hold req high until it receives its ack.
REQ-027 Deasserting req before grant SHALL withdraw the request; deassertion after grant SHALL be ignored and the transfer SHALL complete.
REQ-028 Requests arriving outside IDLE SHALL wait; they SHALL NOT be lost while req is held high.
REQ-029 A req still high in the cycle its ack pulses SHALL be treated as a new request at the next IDLE sample.
REQ-030 When req0 and req1 are high in the same IDLE cycle, the grant SHALL follow REQ-036 and REQ-037.
REQ-031 Slot and wait counters SHALL be sized from the parameters and SHALL NOT wrap within a count.

Reset
REQ-032 When resetn is low, LCD_E, LCD_RS, LCD_RW, ack0, ack1 and ready SHALL be 0, LCD_DATA SHALL be 0x00, and the state SHALL be INIT_WAIT with all counters cleared.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer with no ack and restart the full initialisation sequence.
REQ-034 The round-robin pointer SHALL reset so that requester 0 wins the first tie.

Configuration
REQ-035 The macro LCD_ARB_ROUND_ROBIN_EN SHALL select the tie-break policy.
REQ-036 With LCD_ARB_ROUND_ROBIN_EN defined, a tie SHALL be granted to the requester not served last, and the pointer SHALL update on each grant.
REQ-037 Without LCD_ARB_ROUND_ROBIN_EN, req0 SHALL always win a tie, and the pointer logic SHALL be absent.

Structure
REQ-038 The shared package lcd_pkg SHALL hold the state enum and the command constants (0x3C function set, 0x0C display on, 0x06 entry mode, 0x01 clear, 0x80/0xC0 row addresses).
REQ-039 The sub-module lcd_byte_slot SHALL hold the slot counter, generate LCD_E, and output slot_done in the last slot cycle; the arbiter FSM SHALL sequence bytes on slot_done.

Verification
REQ-040 Reset release with defaults, no requests -> LCD_DATA shows 0x3C, 0x0C, 0x06, 0x01 with one E pulse each starting at clock 70, and ready rises at clock 286.
REQ-041 req0=1, line0=0, txt0="HELLO WORLD     " after ready -> slots carry 0x80, 0x48, 0x45, ..., 0x20 with RS 0 then 1, and ack0 pulses 69 clocks after the grant.
REQ-042 req0 and req1 high together, repeated four times, with round-robin enabled -> grant order 0,1,0,1; with round-robin disabled -> 0,0,0,0 while req0 is held.
REQ-043 req1 asserted during req0's transfer -> req1 is granted in the first IDLE cycle after ack0, and row 1 writes start with 0xC0.
REQ-044 resetn pulsed low in the middle of a CHAR slot -> all outputs go to 0 asynchronously, no ack, and initialisation restarts with 0x3C at clock 70.
REQ-045 req0 dropped during a transfer -> all 16 characters are still written and ack0 still pulses.
